// File: rtl/key_led_ctrl.sv
// key_led_ctrl: classifies a debounced key into short / long / double press
// events, timed in CE ticks, and steps a four-mode LED sequencer
// (off / on / slow blink / fast blink) from those events.
module key_led_ctrl #(
  parameter int unsigned LONG_TICKS = 16,
  parameter int unsigned DBL_TICKS  = 4,
  parameter int unsigned BLINK_SLOW = 8,
  parameter int unsigned BLINK_FAST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       key_lvl,
  output logic       evt_short,
  output logic       evt_long,
  output logic       evt_double,
  output logic [1:0] mode,
  output logic       led_out
);

  // Counter compare values: a limit is reached on the tick where cnt == LIMIT-1
  localparam logic [15:0] LONG_LIM = 16'(LONG_TICKS - 1);
  localparam logic [15:0] DBL_LIM  = 16'(DBL_TICKS - 1);
  localparam logic [15:0] SLOW_LIM = 16'(BLINK_SLOW - 1);
  localparam logic [15:0] FAST_LIM = 16'(BLINK_FAST - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t      state;
  logic        key_prev;
  logic [15:0] cnt;
  logic [15:0] bcnt;
  logic        rise;
  logic        fall;
  logic        long_hit;
  logic        dbl_hit;
  logic [1:0]  mode_nx;
  logic [15:0] blink_lim;

  // Edges are seen on every clock, independent of ce
  assign rise     = key_lvl & ~key_prev;
  assign fall     = ~key_lvl & key_prev;
  assign long_hit = ce && (cnt == LONG_LIM);
  assign dbl_hit  = ce && (cnt == DBL_LIM);

  // Previous key level for edge detection; zero at reset so a key held
  // across reset release is seen as a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev <= 1'b0;
    end else begin
      key_prev <= key_lvl;
    end
  end

  // Press classifier: tick counter restarts on every state change, edges
  // take priority over a limit tick landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      evt_short  <= 1'b0;
      evt_long   <= 1'b0;
      evt_double <= 1'b0;
    end else begin
      evt_short  <= 1'b0;
      evt_long   <= 1'b0;
      evt_double <= 1'b0;
      if (ce) begin
        cnt <= cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (long_hit) begin
            state    <= HOLD;
            cnt      <= '0;
            evt_long <= 1'b1;
          end
        end
        WAIT2: begin
          if (rise) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (dbl_hit) begin
            state     <= IDLE;
            cnt       <= '0;
            evt_short <= 1'b1;
          end
        end
        PRESS2: begin
          if (fall) begin
            state      <= IDLE;
            cnt        <= '0;
            evt_double <= 1'b1;
          end
        end
        HOLD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Mode that the registered event selects for the next edge
  always_comb begin
    mode_nx = mode;
    if (evt_short) begin
      mode_nx = mode + 2'd1;
    end else if (evt_long) begin
      mode_nx = 2'd0;
    end else if (evt_double) begin
      mode_nx = 2'd3;
    end
  end

  // Half-period compare value for the current blink mode
  always_comb begin
    blink_lim = (mode == 2'd2) ? SLOW_LIM : FAST_LIM;
  end

  // LED sequencer: a real mode change restarts the blink phase lit;
  // otherwise blink modes toggle every half-period of ce ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= 2'd0;
      led_out <= 1'b0;
      bcnt    <= '0;
    end else begin
      mode <= mode_nx;
      if (mode_nx != mode) begin
        bcnt    <= '0;
        led_out <= (mode_nx != 2'd0);
      end else if (mode[1]) begin
        if (ce) begin
          if (bcnt == blink_lim) begin
            bcnt    <= '0;
            led_out <= ~led_out;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
      end else begin
        bcnt    <= '0;
        led_out <= mode[0];
      end
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed scenarios followed by random key/ce/reset
// traffic, every cycle compared against a tick-stamp based reference model.
module tb_key_led_ctrl;

  localparam int LONG = 8;
  localparam int DBL  = 4;
  localparam int SLOW = 8;
  localparam int FAST = 2;

  // Press phases of the reference model
  localparam int PH_NONE        = 0;
  localparam int PH_FIRST_HELD  = 1;
  localparam int PH_GAP         = 2;
  localparam int PH_SECOND_HELD = 3;
  localparam int PH_LONG_HELD   = 4;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       key_lvl;
  logic       evt_short;
  logic       evt_long;
  logic       evt_double;
  logic [1:0] mode;
  logic       led_out;

  int vectors;
  int miscompares;
  int n_checks;

  // Reference model state
  int   m_phase;
  int   m_ticks;   // global count of ce ticks since reset
  int   m_stamp;   // tick count at entry into the current phase
  bit   m_prev;
  int   m_mode;
  int   m_blink;   // ce ticks since the current blink mode was entered
  bit   e_s;
  bit   e_l;
  bit   e_d;

  key_led_ctrl #(
    .LONG_TICKS(LONG),
    .DBL_TICKS (DBL),
    .BLINK_SLOW(SLOW),
    .BLINK_FAST(FAST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .key_lvl   (key_lvl),
    .evt_short (evt_short),
    .evt_long  (evt_long),
    .evt_double(evt_double),
    .mode      (mode),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_stamp = m_ticks;
  endtask

  function automatic bit exp_led();
    int half;
    if (m_mode == 0) return 1'b0;
    if (m_mode == 1) return 1'b1;
    half = (m_mode == 2) ? SLOW : FAST;
    return ((m_blink / half) % 2) == 0;
  endfunction

  // Advance the model by one clock edge with the sampled inputs
  task automatic model_edge(input bit k, input bit c, input bit r);
    int  nm;
    int  elapsed;
    bit  rise_m;
    bit  fall_m;
    if (r) begin
      m_phase = PH_NONE;
      m_ticks = 0;
      m_stamp = 0;
      m_prev  = 1'b0;
      m_mode  = 0;
      m_blink = 0;
      e_s = 1'b0; e_l = 1'b0; e_d = 1'b0;
    end else begin
      nm = m_mode;
      if (e_s)      nm = (m_mode + 1) % 4;
      else if (e_l) nm = 0;
      else if (e_d) nm = 3;
      if (nm != m_mode)           m_blink = 0;
      else if (c && m_mode >= 2)  m_blink++;
      m_mode = nm;

      rise_m = k && !m_prev;
      fall_m = !k && m_prev;
      if (c) m_ticks++;
      elapsed = m_ticks - m_stamp;
      e_s = 1'b0; e_l = 1'b0; e_d = 1'b0;
      case (m_phase)
        PH_NONE:        if (rise_m) enter(PH_FIRST_HELD);
        PH_FIRST_HELD: begin
          if (fall_m) enter(PH_GAP);
          else if (c && elapsed == LONG) begin e_l = 1'b1; enter(PH_LONG_HELD); end
        end
        PH_GAP: begin
          if (rise_m) enter(PH_SECOND_HELD);
          else if (c && elapsed == DBL) begin e_s = 1'b1; enter(PH_NONE); end
        end
        PH_SECOND_HELD: if (fall_m) begin e_d = 1'b1; enter(PH_NONE); end
        PH_LONG_HELD:   if (fall_m) enter(PH_NONE);
        default:        enter(PH_NONE);
      endcase
      m_prev = k;
    end
  endtask

  // One clock: drive, let the edge happen, update model, compare 1 ns later
  task automatic step(input bit k, input bit c, input bit r);
    key_lvl = k;
    ce      = c;
    rst     = r;
    @(posedge clk);
    model_edge(k, c, r);
    #1;
    vectors++;
    chk("evt_short",  {1'b0, evt_short},  {1'b0, e_s});
    chk("evt_long",   {1'b0, evt_long},   {1'b0, e_l});
    chk("evt_double", {1'b0, evt_double}, {1'b0, e_d});
    chk("mode",       mode,               2'(m_mode));
    chk("led_out",    {1'b0, led_out},    {1'b0, exp_led()});
  endtask

  // n CE ticks, one ce every 4 clocks, key held at k
  task automatic ticks(input bit k, input int n);
    for (int i = 0; i < n; i++) begin
      step(k, 1'b0, 1'b0);
      step(k, 1'b0, 1'b0);
      step(k, 1'b0, 1'b0);
      step(k, 1'b1, 1'b0);
    end
  endtask

  task automatic short_press();
    ticks(1'b1, 3);
    ticks(1'b0, 4);
    ticks(1'b0, 1);
  endtask

  initial begin
    int flip_div;
    bit k;
    vectors = 0; miscompares = 0; n_checks = 0;
    rst = 1'b1; ce = 1'b0; key_lvl = 1'b0;
    m_phase = PH_NONE; m_ticks = 0; m_stamp = 0; m_prev = 1'b0;
    m_mode = 0; m_blink = 0; e_s = 1'b0; e_l = 1'b0; e_d = 1'b0;

    // Reset with ce toggling
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("reset_mode", mode, 2'd0);
    chk("reset_led", {1'b0, led_out}, 2'd0);
    ticks(1'b0, 2);

    // Short press: mode 0 -> 1
    short_press();
    chk("short_mode", mode, 2'd1);
    chk("short_led", {1'b0, led_out}, 2'd1);

    // Go to mode 2, then long press -> mode 0, release gives nothing
    short_press();
    ticks(1'b1, 8);
    ticks(1'b1, 5);
    ticks(1'b0, 6);
    chk("long_mode", mode, 2'd0);
    chk("long_led", {1'b0, led_out}, 2'd0);

    // Mode 1, then double press -> mode 3 fast blink
    short_press();
    ticks(1'b1, 2);
    ticks(1'b0, 2);
    ticks(1'b1, 1);
    ticks(1'b0, 1);
    chk("double_mode", mode, 2'd3);
    ticks(1'b0, 6);

    // Release on the exact LONG limit tick: short press instead, 3 -> 0
    ticks(1'b1, 7);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    ticks(1'b0, 5);
    chk("fall_wins_mode", mode, 2'd0);

    // Second rise on the DBL limit tick: double press, 0 -> 3
    ticks(1'b1, 2);
    ticks(1'b0, 3);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    ticks(1'b1, 1);
    ticks(1'b0, 2);
    chk("rise_wins_mode", mode, 2'd3);

    // Step to mode 2 (3->0->1->2), then reset mid-press
    short_press();
    short_press();
    short_press();
    ticks(1'b0, 5);
    chk("pre_reset_mode", mode, 2'd2);
    ticks(1'b1, 2);
    step(1'b1, 1'b0, 1'b1);
    chk("midreset_mode", mode, 2'd0);
    chk("midreset_led", {1'b0, led_out}, 2'd0);
    ticks(1'b1, 2);
    ticks(1'b0, 6);

    // Random traffic in blocks with varying key activity
    k = 1'b0;
    for (int b = 0; b < 8; b++) begin
      flip_div = 4 + 6 * b;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, flip_div - 1) == 0) k = ~k;
        step(k, $urandom_range(0, 2) == 0, $urandom_range(0, 599) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
